// File: rtl/fifo_tx_serializer_pkg.sv
// Shared types and helpers for the FIFO-draining serial transmitter.
package fifo_tx_serializer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic TX_IDLE_LVL = 1'b1;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_tx_serializer_if.sv
// Read side of the word FIFO: pop request, empty flag and read data.
interface fifo_tx_serializer_if #(
  parameter int unsigned DATA_W = 10
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;

  // The serializer pops words; the FIFO answers.
  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/fifo_tx_serializer_baud_tick_gen.sv
// Bit-period timer: tick marks the last clk cycle of every serial bit.
module baud_tick_gen
  import fifo_tx_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; clear holds the phase at zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Bit boundary strobe.
  always_comb begin
    tick = (cnt == LAST) && !clear;
  end
endmodule

// File: rtl/fifo_tx_serializer.sv
// Pops words from the FIFO and sends each as start, data LSB first,
// optional even parity, stop on the tx line.
module fifo_tx_serializer
  import fifo_tx_serializer_pkg::*;
#(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  fifo_tx_serializer_if.master   fifo,
  output logic                   tx,
  output logic                   busy,
  output logic                   word_done
);
  localparam int unsigned IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [IW-1:0]     bit_idx, bit_idx_nx;
  logic              par_q, par_nx;
  logic              tx_nx, rd_en_nx, busy_nx, done_nx;
  logic              tick, baud_clr;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clr),
    .tick  (tick)
  );

  // Next state and next registered outputs; every output leaves a flop.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_idx_nx = bit_idx;
    par_nx     = par_q;
    tx_nx      = tx;
    rd_en_nx   = 1'b0;
    busy_nx    = busy;
    done_nx    = 1'b0;
    baud_clr   = 1'b1;
    case (state)
      S_IDLE: begin
        tx_nx = TX_IDLE_LVL;
        if (enable && !fifo.fifo_empty) begin
          rd_en_nx = 1'b1;
          busy_nx  = 1'b1;
          state_nx = S_POP;
        end
      end
      S_POP: begin
        state_nx = S_LOAD;
      end
      S_LOAD: begin
        shreg_nx = fifo.fifo_dout;
        par_nx   = ^fifo.fifo_dout;
        tx_nx    = 1'b0;
        state_nx = S_START;
      end
      S_START: begin
        baud_clr = 1'b0;
        if (tick) begin
          tx_nx      = shreg[0];
          bit_idx_nx = '0;
          state_nx   = S_DATA;
        end
      end
      S_DATA: begin
        baud_clr = 1'b0;
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            if (PARITY_EN) begin
              tx_nx    = par_q;
              state_nx = S_PARITY;
            end else begin
              tx_nx    = TX_IDLE_LVL;
              state_nx = S_STOP;
            end
          end else begin
            // tx takes the bit that becomes shreg[0] after this shift.
            shreg_nx   = shreg >> 1;
            tx_nx      = shreg[1];
            bit_idx_nx = bit_idx + IW'(1);
          end
        end
      end
      S_PARITY: begin
        baud_clr = 1'b0;
        if (tick) begin
          tx_nx    = TX_IDLE_LVL;
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        baud_clr = 1'b0;
        if (tick) begin
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      shreg           <= '0;
      bit_idx         <= '0;
      par_q           <= 1'b0;
      tx              <= TX_IDLE_LVL;
      fifo.fifo_rd_en <= 1'b0;
      busy            <= 1'b0;
      word_done       <= 1'b0;
    end else begin
      state           <= state_nx;
      shreg           <= shreg_nx;
      bit_idx         <= bit_idx_nx;
      par_q           <= par_nx;
      tx              <= tx_nx;
      fifo.fifo_rd_en <= rd_en_nx;
      busy            <= busy_nx;
      word_done       <= done_nx;
    end
  end
endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Bench: two serializers (no parity / even parity) fed by behavioural FIFOs.
module tb_fifo_tx_serializer;
  localparam int unsigned CPB = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] tx_v, busy_v, wd_v;

  fifo_tx_serializer_if #(.DATA_W(10)) if0 ();
  fifo_tx_serializer_if #(.DATA_W(10)) if1 ();

  fifo_tx_serializer #(.DATA_W(10), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .fifo(if0.master),
    .tx(tx_v[0]), .busy(busy_v[0]), .word_done(wd_v[0])
  );

  fifo_tx_serializer #(.DATA_W(10), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo(if1.master),
    .tx(tx_v[1]), .busy(busy_v[1]), .word_done(wd_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned k;
    logic [9:0]  word;
    logic [12:0] seq;
  } vec_t;

  int unsigned checks, errors, cyc;
  logic [9:0]  fq0[$], fq1[$], exp0[$], exp1[$];
  int unsigned rd_cnt[2], done_cnt[2], wd_cyc[2];
  bit          wd_seen[2];
  logic [12:0] last_seq[2];
  int unsigned gapq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int unsigned k, input logic [9:0] w);
    if (k == 0) begin
      fq0.push_back(w); exp0.push_back(w); if0.fifo_empty = 1'b0;
    end else begin
      fq1.push_back(w); exp1.push_back(w); if1.fifo_empty = 1'b0;
    end
  endtask

  // FIFO read port: one-cycle read latency after rd_en.
  task automatic fifo_srv();
    forever begin
      @(posedge clk);
      cyc++;
      if (if0.fifo_rd_en === 1'b1 && fq0.size() > 0) begin
        if0.fifo_dout  = fq0.pop_front();
        if0.fifo_empty = (fq0.size() == 0);
      end
      if (if1.fifo_rd_en === 1'b1 && fq1.size() > 0) begin
        if1.fifo_dout  = fq1.pop_front();
        if1.fifo_empty = (fq1.size() == 0);
      end
    end
  endtask

  task automatic rdmon(input int unsigned k);
    logic rd, em;
    forever begin
      @(negedge clk);
      rd = (k == 0) ? if0.fifo_rd_en : if1.fifo_rd_en;
      em = (k == 0) ? if0.fifo_empty : if1.fifo_empty;
      if (rst === 1'b0 && rd === 1'b1) begin
        rd_cnt[k]++;
        chk("rd_en_while_empty", 32'(em), 32'd0);
      end
    end
  endtask

  // Frame decoder: samples mid-bit, then checks word_done timing and scoreboard.
  task automatic mon(input int unsigned k);
    int unsigned nb, t0;
    logic [12:0] seq;
    logic        ok;
    logic [9:0]  e;
    nb = (k == 1) ? 13 : 12;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_v[k] === 1'b0) begin
        t0 = cyc; ok = 1'b1; seq = '0;
        if (k == 0 && wd_seen[0]) gapq.push_back(t0 - wd_cyc[0]);
        for (int unsigned j = 0; j < nb; j++) begin
          repeat ((j == 0) ? 2 : 4) begin
            @(negedge clk);
            if (rst !== 1'b0) ok = 1'b0;
          end
          if (!ok) break;
          seq[j] = tx_v[k];
          if (j == 0) chk("busy_in_frame", 32'(busy_v[k]), 32'd1);
        end
        if (ok) begin
          @(negedge clk);
          chk("word_done_early", 32'(wd_v[k]), 32'd0);
          @(negedge clk);
          chk("word_done_at_frame_end", 32'(wd_v[k]), 32'd1);
          wd_cyc[k] = cyc; wd_seen[k] = 1'b1;
          last_seq[k] = seq;
          done_cnt[k]++;
          if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got data 0x%0h, want no frame", seq[10:1]);
          end else begin
            if (k == 0) e = exp0.pop_front();
            else        e = exp1.pop_front();
            chk("frame_data", 32'(seq[10:1]), 32'(e));
            chk("start_bit", 32'(seq[0]), 32'd0);
            chk("stop_bit", 32'(seq[nb-1]), 32'd1);
            if (k == 1) chk("parity_bit", 32'(seq[11]), 32'(^e));
          end
        end else begin
          wd_seen[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_done(input int unsigned k, input int unsigned target, input string name);
    int unsigned n;
    n = 0;
    while (done_cnt[k] < target && n < 400) begin tick(); n++; end
    chk(name, done_cnt[k], target);
  endtask

  task automatic wait_fall(input int unsigned k);
    int unsigned n;
    n = 0;
    while (tx_v[k] !== 1'b0 && n < 100) begin tick(); n++; end
    chk("tx_fall_seen", 32'(tx_v[k]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int unsigned k, r0, d0;

    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; enable = 1'b1;
    if0.fifo_empty = 1'b1; if0.fifo_dout = '0;
    if1.fifo_empty = 1'b1; if1.fifo_dout = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      rd_cnt[i] = 0; done_cnt[i] = 0; wd_cyc[i] = 0; wd_seen[i] = 1'b0; last_seq[i] = '0;
    end

    // Expected tx sequences, bit j of seq is the j-th serial bit (start first).
    vt[0] = '{0, 10'h2A5, 13'b0_1_1010100101_0};
    vt[1] = '{1, 10'h001, 13'b1_1_0000000001_0};
    vt[2] = '{1, 10'h003, 13'b1_0_0000000011_0};
    vt[3] = '{0, 10'h3FF, 13'b0_1_1111111111_0};
    vt[4] = '{0, 10'h000, 13'b0_1_0000000000_0};
    vt[5] = '{1, 10'h155, 13'b1_1_0101010101_0};

    fork
      fifo_srv();
      mon(0);
      mon(1);
      rdmon(0);
      rdmon(1);
    join_none

    // Reset with an empty FIFO and enable high.
    repeat (3) tick();
    @(negedge clk);
    chk("reset_outputs", {24'd0, tx_v, busy_v, wd_v, if0.fifo_rd_en, if1.fifo_rd_en}, 32'b11_00_00_0_0);
    tick();
    rst = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_hold", {24'd0, tx_v, busy_v, wd_v, if0.fifo_rd_en, if1.fifo_rd_en}, 32'b11_00_00_0_0);
    end
    tick();

    // Single words through both parity settings.
    for (int unsigned i = 0; i < 6; i++) begin
      k = vt[i].k; r0 = rd_cnt[k]; d0 = done_cnt[k];
      put(k, vt[i].word);
      wait_done(k, d0 + 1, "vec_done");
      tick();
      chk("vec_rd_pulses", rd_cnt[k] - r0, 32'd1);
      chk("vec_tx_sequence", 32'(last_seq[k]), 32'(vt[i].seq));
    end

    // Three words back to back.
    gapq.delete();
    r0 = rd_cnt[0]; d0 = done_cnt[0];
    put(0, 10'h0F0); put(0, 10'h30C); put(0, 10'h1E7);
    wait_done(0, d0 + 3, "b2b_done");
    tick();
    chk("b2b_rd_pulses", rd_cnt[0] - r0, 32'd3);
    chk("b2b_gap_count", gapq.size(), 32'd3);
    chk("b2b_gap_2", (gapq.size() > 1) ? gapq[1] : 0, 32'd3);
    chk("b2b_gap_3", (gapq.size() > 2) ? gapq[2] : 0, 32'd3);
    repeat (20) tick();
    chk("b2b_no_extra_pop", rd_cnt[0] - r0, 32'd3);
    chk("b2b_fifo_empty", 32'(if0.fifo_empty), 32'd1);

    // Drop enable during data bit 4 with two words queued.
    r0 = rd_cnt[0]; d0 = done_cnt[0];
    put(0, 10'h2C3); put(0, 10'h11D);
    wait_fall(0);
    repeat (21) tick();
    enable = 1'b0;
    wait_done(0, d0 + 1, "en_low_frame_done");
    repeat (30) tick();
    chk("en_low_rd_pulses", rd_cnt[0] - r0, 32'd1);
    chk("en_low_done", done_cnt[0] - d0, 32'd1);
    chk("en_low_busy", 32'(busy_v[0]), 32'd0);
    enable = 1'b1;
    wait_done(0, d0 + 2, "en_high_done");
    tick();
    chk("en_high_rd_pulses", rd_cnt[0] - r0, 32'd2);

    // Reset during data bit 5; the in-flight word is lost.
    r0 = rd_cnt[0]; d0 = done_cnt[0];
    put(0, 10'h3A6); put(0, 10'h05B);
    wait_fall(0);
    repeat (25) tick();
    rst = 1'b1;
    void'(exp0.pop_front());
    tick();
    @(negedge clk);
    chk("abort_outputs", {29'd0, tx_v[0], busy_v[0], wd_v[0]}, 32'b100);
    chk("abort_no_done", done_cnt[0] - d0, 32'd0);
    tick();
    rst = 1'b0;
    wait_done(0, d0 + 1, "after_abort_done");
    tick();
    chk("after_abort_rd_pulses", rd_cnt[0] - r0, 32'd2);
    chk("scoreboard_drained", exp0.size() + exp1.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
